pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline.
- Detects load-use hazards between the ID and EX stages.
- Squashes younger instructions when a branch resolves taken in MEM.
- Freezes the whole pipeline while a multi-cycle data-memory access completes.
- Drives every pipeline-register write/bubble/flush control and keeps saturating stall and flush statistics.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/pipeline_hazard_controller_load_use.sv | 35 +++
 rtl/pipeline_hazard_controller.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard
//                controller: sequencer state encoding, the hard-wired zero
//                register index and the memory-wait counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // RUN: normal issue.  MEM_WAIT: multi-cycle data-memory access in flight.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    // Register x0 is hard-wired to zero; it never carries a true dependency.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Width of the memory-wait down-counter (covers latencies up to 16).
    localparam int WAIT_W = 4;

    // Value loaded into the wait counter when a freeze starts. The first
    // frozen cycle is spent in RUN, so the counter covers the remaining
    // latency-2 frozen cycles before the release cycle.
    function automatic logic [WAIT_W-1:0] wait_init(input int latency);
        if (latency < 2) begin
            return '0;
        end
        return WAIT_W'(latency - 2);
    endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_controller_load_use.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Combinational load-use hazard compare between the
//                instruction in ID and a load sitting in EX.
//  Ports       : id_rs1, id_rs2   - source register fields in ID
//                id_uses_rs2      - ID instruction actually reads rs2
//                ex_rd            - destination register of the EX stage
//                ex_mem_read      - EX stage holds a load
//                load_use         - hazard detected (stall required)
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = (ex_rd == id_rs1);
    // rs2 only matters when the instruction really reads it (I-type loads
    // carry immediate bits in that field).
    assign w_rs2_hit = id_uses_rs2 && (ex_rd == id_rs2);

    assign load_use = ex_mem_read && (ex_rd != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_controller
//  Description : Central stall/flush sequencer for the 5-stage pipeline.
//                Freezes the pipe during multi-cycle memory accesses,
//                squashes younger instructions on a taken branch in MEM and
//                inserts a single bubble on a load-use hazard. Keeps
//                saturating stall and flush statistics.
//  Parameters  : MEM_LATENCY - cycles a load/store occupies MEM (1..16)
//                CNT_W       - statistics counter width
//  Ports       : clk, reset (sync, active-low)
//                id_*/ex_*   - hazard detection inputs
//                mem_*       - branch resolution and memory access inputs
//                pc_write, *_write, *_flush, *_bubble - pipeline controls
//                stall_count, flush_count - saturating statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             mem_branch,
    input  logic             mem_branch_taken,
    input  logic             mem_access,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [WAIT_W-1:0] c_wait_init = wait_init(MEM_LATENCY);

    ctrl_state_t       r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_count;
    logic [CNT_W-1:0]  r_flush_count;

    logic w_multi_cycle;
    logic w_load_use;
    logic w_taken;
    logic w_freeze_entry;
    logic w_freeze;
    logic w_branch_act;

    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_write;
    logic w_idex_bubble;
    logic w_exmem_write;
    logic w_exmem_flush;
    logic w_memwb_bubble;

    // A single-cycle memory never needs to freeze the pipe.
    generate
        if (MEM_LATENCY > 1) begin : g_multi_cycle_mem
            assign w_multi_cycle = 1'b1;
        end else begin : g_single_cycle_mem
            assign w_multi_cycle = 1'b0;
        end
    endgenerate

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (w_load_use)
    );

    assign w_taken = mem_branch && mem_branch_taken;

    // A branch and a memory op can never legally share EX/MEM; if they do,
    // the branch wins and no freeze is started.
    assign w_freeze_entry = (r_state == RUN) && mem_access && !mem_branch && w_multi_cycle;
    // In MEM_WAIT the last cycle (wait_cnt==0) releases the freeze; the
    // still-asserted mem_access belongs to the same instruction and is ignored.
    assign w_freeze       = w_freeze_entry || ((r_state == MEM_WAIT) && (r_wait_cnt != '0));

    always_comb begin
        w_pc_write     = 1'b1;
        w_ifid_write   = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_write   = 1'b1;
        w_idex_bubble  = 1'b0;
        w_exmem_write  = 1'b1;
        w_exmem_flush  = 1'b0;
        w_memwb_bubble = 1'b0;
        w_branch_act   = 1'b0;
        if (!reset) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_ifid_flush   = 1'b1;
            w_idex_write   = 1'b0;
            w_idex_bubble  = 1'b1;
            w_exmem_write  = 1'b0;
            w_exmem_flush  = 1'b1;
            w_memwb_bubble = 1'b1;
        end else if (w_freeze) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_idex_write   = 1'b0;
            w_exmem_write  = 1'b0;
            w_memwb_bubble = 1'b1;
        end else if (w_taken) begin
            // The load (if any) in EX is squashed too, so load-use is moot.
            w_branch_act   = 1'b1;
            w_ifid_flush   = 1'b1;
            w_idex_bubble  = 1'b1;
            w_exmem_flush  = 1'b1;
        end else if (w_load_use) begin
            w_pc_write     = 1'b0;
            w_ifid_write   = 1'b0;
            w_idex_bubble  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_freeze_entry) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= c_wait_init;
                    end
                end
                MEM_WAIT: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
                    end else begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase

            if (!w_pc_write && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (w_branch_act && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign pc_write     = w_pc_write;
    assign ifid_write   = w_ifid_write;
    assign ifid_flush   = w_ifid_flush;
    assign idex_write   = w_idex_write;
    assign idex_bubble  = w_idex_bubble;
    assign exmem_write  = w_exmem_write;
    assign exmem_flush  = w_exmem_flush;
    assign memwb_bubble = w_memwb_bubble;
    assign stall_count  = r_stall_count;
    assign flush_count  = r_flush_count;

endmodule : pipeline_hazard_controller
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_controller
//  Description : Directed self-checking bench. Four controller instances
//                (latency 1, 3, 4 and a 4-bit-counter variant) share one
//                stimulus set; each check targets the relevant instance.
//                Control outputs are packed as
//                {pc_write, ifid_write, ifid_flush, idex_write,
//                 idex_bubble, exmem_write, exmem_flush, memwb_bubble}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    localparam logic [7:0] c_dflt   = 8'hD4;
    localparam logic [7:0] c_rst    = 8'h2B;
    localparam logic [7:0] c_freeze = 8'h01;
    localparam logic [7:0] c_branch = 8'hFE;
    localparam logic [7:0] c_lduse  = 8'h1C;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_uses_rs2 = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       ex_mem_read = 1'b0;
    logic       mem_branch = 1'b0;
    logic       mem_branch_taken = 1'b0;
    logic       mem_access = 1'b0;

    wire [7:0]  w_outs_l1, w_outs_l3, w_outs_l4, w_outs_c4;
    wire [15:0] w_stall_l1, w_flush_l1, w_stall_l3, w_flush_l3, w_stall_l4, w_flush_l4;
    wire [3:0]  w_stall_c4, w_flush_c4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.MEM_LATENCY(1), .CNT_W(16)) u_l1 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_branch(mem_branch),
        .mem_branch_taken(mem_branch_taken), .mem_access(mem_access),
        .pc_write(w_outs_l1[7]), .ifid_write(w_outs_l1[6]), .ifid_flush(w_outs_l1[5]),
        .idex_write(w_outs_l1[4]), .idex_bubble(w_outs_l1[3]), .exmem_write(w_outs_l1[2]),
        .exmem_flush(w_outs_l1[1]), .memwb_bubble(w_outs_l1[0]),
        .stall_count(w_stall_l1), .flush_count(w_flush_l1));

    pipeline_hazard_controller #(.MEM_LATENCY(3), .CNT_W(16)) u_l3 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_branch(mem_branch),
        .mem_branch_taken(mem_branch_taken), .mem_access(mem_access),
        .pc_write(w_outs_l3[7]), .ifid_write(w_outs_l3[6]), .ifid_flush(w_outs_l3[5]),
        .idex_write(w_outs_l3[4]), .idex_bubble(w_outs_l3[3]), .exmem_write(w_outs_l3[2]),
        .exmem_flush(w_outs_l3[1]), .memwb_bubble(w_outs_l3[0]),
        .stall_count(w_stall_l3), .flush_count(w_flush_l3));

    pipeline_hazard_controller #(.MEM_LATENCY(4), .CNT_W(16)) u_l4 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_branch(mem_branch),
        .mem_branch_taken(mem_branch_taken), .mem_access(mem_access),
        .pc_write(w_outs_l4[7]), .ifid_write(w_outs_l4[6]), .ifid_flush(w_outs_l4[5]),
        .idex_write(w_outs_l4[4]), .idex_bubble(w_outs_l4[3]), .exmem_write(w_outs_l4[2]),
        .exmem_flush(w_outs_l4[1]), .memwb_bubble(w_outs_l4[0]),
        .stall_count(w_stall_l4), .flush_count(w_flush_l4));

    pipeline_hazard_controller #(.MEM_LATENCY(2), .CNT_W(4)) u_c4 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_branch(mem_branch),
        .mem_branch_taken(mem_branch_taken), .mem_access(mem_access),
        .pc_write(w_outs_c4[7]), .ifid_write(w_outs_c4[6]), .ifid_flush(w_outs_c4[5]),
        .idex_write(w_outs_c4[4]), .idex_bubble(w_outs_c4[3]), .exmem_write(w_outs_c4[2]),
        .exmem_flush(w_outs_c4[1]), .memwb_bubble(w_outs_c4[0]),
        .stall_count(w_stall_c4), .flush_count(w_flush_c4));

    // Branch and memory op must never share EX/MEM.
    always @(posedge clk) begin
        if (reset) begin
            assert (!(mem_branch && mem_access))
                else $error("protocol violation: mem_branch with mem_access");
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0; ex_rd = '0; ex_mem_read = 1'b0;
        mem_branch = 1'b0; mem_branch_taken = 1'b0; mem_access = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic use2);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = use2;
    endtask

    initial begin
        // ---- reset values ----
        clear_inputs();
        #2;
        check_eq("reset_outs_l1", 32'(w_outs_l1), 32'(c_rst));
        check_eq("reset_outs_l4", 32'(w_outs_l4), 32'(c_rst));
        tick();
        check_eq("reset_stall_l3", 32'(w_stall_l3), 32'd0);
        check_eq("reset_flush_l3", 32'(w_flush_l3), 32'd0);
        reset = 1'b1;
        #1;
        check_eq("run_default_l1", 32'(w_outs_l1), 32'(c_dflt));

        // ---- single load-use bubble ----
        set_load_use(5'd5, 5'd5, 5'd0, 1'b0);
        #1;
        check_eq("lduse_outs", 32'(w_outs_l1), 32'(c_lduse));
        tick();
        clear_inputs();
        #1;
        check_eq("lduse_next_default", 32'(w_outs_l1), 32'(c_dflt));
        check_eq("lduse_stall_count", 32'(w_stall_l1), 32'd1);

        // ---- x0 and rs2 masking ----
        apply_reset();
        set_load_use(5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        check_eq("x0_no_stall", 32'(w_outs_l1), 32'(c_dflt));
        set_load_use(5'd7, 5'd1, 5'd7, 1'b0);
        #1;
        check_eq("rs2_masked", 32'(w_outs_l1), 32'(c_dflt));
        id_uses_rs2 = 1'b1;
        #1;
        check_eq("rs2_used_stall", 32'(w_outs_l1), 32'(c_lduse));

        // ---- memory freeze: latency 3 (2 frozen), latency 4 (3 frozen) ----
        apply_reset();
        mem_access = 1'b1;
        #1;
        check_eq("frz_c0_l3", 32'(w_outs_l3), 32'(c_freeze));
        check_eq("frz_c0_l1_none", 32'(w_outs_l1), 32'(c_dflt));
        tick();
        mem_access = 1'b0;
        #1;
        check_eq("frz_c1_l3", 32'(w_outs_l3), 32'(c_freeze));
        tick();
        mem_access = 1'b1;  // release cycle: same instruction, must be ignored
        #1;
        check_eq("frz_c2_l3_release", 32'(w_outs_l3), 32'(c_dflt));
        check_eq("frz_c2_l4", 32'(w_outs_l4), 32'(c_freeze));
        tick();
        mem_access = 1'b0;
        #1;
        check_eq("frz_c3_l3", 32'(w_outs_l3), 32'(c_dflt));
        check_eq("frz_c3_l4_release", 32'(w_outs_l4), 32'(c_dflt));
        tick();
        check_eq("frz_stall_l3", 32'(w_stall_l3), 32'd2);
        check_eq("frz_stall_l4", 32'(w_stall_l4), 32'd3);
        check_eq("frz_stall_l1", 32'(w_stall_l1), 32'd0);

        // ---- taken branch overrides load-use; untaken lets stall through ----
        apply_reset();
        set_load_use(5'd9, 5'd9, 5'd0, 1'b0);
        mem_branch = 1'b1; mem_branch_taken = 1'b1;
        #1;
        check_eq("br_taken_outs", 32'(w_outs_l1), 32'(c_branch));
        tick();
        clear_inputs();
        #1;
        check_eq("br_flush_count", 32'(w_flush_l1), 32'd1);
        check_eq("br_stall_count", 32'(w_stall_l1), 32'd0);
        set_load_use(5'd9, 5'd9, 5'd0, 1'b0);
        mem_branch = 1'b1; mem_branch_taken = 1'b0;
        #1;
        check_eq("br_untaken_lduse", 32'(w_outs_l1), 32'(c_lduse));
        tick();
        clear_inputs();
        #1;
        check_eq("br_untaken_stall", 32'(w_stall_l1), 32'd1);
        check_eq("br_untaken_flush", 32'(w_flush_l1), 32'd1);

        // ---- reset during the 2nd frozen cycle, latency 4 ----
        apply_reset();
        mem_access = 1'b1;
        #1;
        check_eq("rstw_c0_l4", 32'(w_outs_l4), 32'(c_freeze));
        tick();
        mem_access = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("rstw_low_outs", 32'(w_outs_l4), 32'(c_rst));
        tick();
        reset = 1'b1;
        #1;
        check_eq("rstw_after_outs", 32'(w_outs_l4), 32'(c_dflt));
        check_eq("rstw_after_stall", 32'(w_stall_l4), 32'd0);
        check_eq("rstw_after_flush", 32'(w_flush_l4), 32'd0);
        tick();
        check_eq("rstw_no_residual", 32'(w_outs_l4), 32'(c_dflt));

        // ---- statistics saturation with a 4-bit counter ----
        apply_reset();
        set_load_use(5'd3, 5'd3, 5'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        clear_inputs();
        #1;
        check_eq("sat_stall_c4", 32'(w_stall_c4), 32'd15);
        check_eq("sat_stall_l1", 32'(w_stall_l1), 32'd20);
        check_eq("sat_flush_c4", 32'(w_flush_c4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipeline_hazard_controller
`default_nettype wire
